// File: rtl/tomasulo_pkg.sv
// rtl/tomasulo_pkg.sv - shared widths, label constants and entry state type
package tomasulo_pkg;

    localparam int DATA_W  = 32;
    localparam int LABEL_W = 5;
    localparam logic [LABEL_W-1:0] NO_LABEL = '0;

    typedef enum logic [1:0] {
        FREE  = 2'd0,
        WAIT  = 2'd1,
        READY = 2'd2,
        EXEC  = 2'd3
    } rs_state_t;

    // A pending label matches a broadcast only when it is a real label
    function automatic logic label_hit(input logic en,
                                       input logic [LABEL_W-1:0] q,
                                       input logic [LABEL_W-1:0] bc);
        return en && (q != NO_LABEL) && (q == bc);
    endfunction

endpackage

// File: rtl/rs_entry.sv
// rtl/rs_entry.sv - one reservation station slot: state machine plus operand capture and snoop
module rs_entry
    import tomasulo_pkg::*;
#(
    parameter int OP_W  = 4,
    parameter int LABEL = 1
) (
    input  logic               clk,
    input  logic               nRST,
    input  logic               issue,
    input  logic [OP_W-1:0]    issue_op,
    input  logic [DATA_W-1:0]  issue_data1,
    input  logic [DATA_W-1:0]  issue_data2,
    input  logic [LABEL_W-1:0] issue_label1,
    input  logic [LABEL_W-1:0] issue_label2,
    input  logic               bc_en,
    input  logic [LABEL_W-1:0] bc_label,
    input  logic [DATA_W-1:0]  bc_data,
    input  logic               dispatch,
    output rs_state_t          state,
    output logic [OP_W-1:0]    op,
    output logic [DATA_W-1:0]  v1,
    output logic [DATA_W-1:0]  v2
);

    localparam logic [LABEL_W-1:0] OWN = LABEL_W'(LABEL);

    logic [LABEL_W-1:0] q1;
    logic [LABEL_W-1:0] q2;
    logic               byp1;
    logic               byp2;
    logic               snp1;
    logic               snp2;
    logic [LABEL_W-1:0] q1_in;
    logic [LABEL_W-1:0] q2_in;

    // Bypass hits on the incoming labels and snoop hits on the stored labels
    always_comb begin
        byp1  = label_hit(bc_en, issue_label1, bc_label);
        byp2  = label_hit(bc_en, issue_label2, bc_label);
        snp1  = label_hit(bc_en, q1, bc_label);
        snp2  = label_hit(bc_en, q2, bc_label);
        q1_in = byp1 ? NO_LABEL : issue_label1;
        q2_in = byp2 ? NO_LABEL : issue_label2;
    end

    // Entry lifecycle FREE -> WAIT/READY -> EXEC -> FREE with operand capture
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state <= FREE;
            op    <= '0;
            v1    <= '0;
            v2    <= '0;
            q1    <= NO_LABEL;
            q2    <= NO_LABEL;
        end else begin
            case (state)
                FREE: begin
                    if (issue) begin
                        op    <= issue_op;
                        v1    <= byp1 ? bc_data : issue_data1;
                        v2    <= byp2 ? bc_data : issue_data2;
                        q1    <= q1_in;
                        q2    <= q2_in;
                        state <= (q1_in == NO_LABEL && q2_in == NO_LABEL) ? READY : WAIT;
                    end
                end
                WAIT: begin
                    if (snp1) begin
                        v1 <= bc_data;
                        q1 <= NO_LABEL;
                    end
                    if (snp2) begin
                        v2 <= bc_data;
                        q2 <= NO_LABEL;
                    end
                    if ((snp1 || q1 == NO_LABEL) && (snp2 || q2 == NO_LABEL))
                        state <= READY;
                end
                READY: begin
                    if (dispatch)
                        state <= EXEC;
                end
                EXEC: begin
                    if (bc_en && bc_label == OWN)
                        state <= FREE;
                end
                default: state <= FREE;
            endcase
        end
    end

endmodule

// File: rtl/reservation_station.sv
// rtl/reservation_station.sv - tag-based reservation station with issue allocator and dispatch mux
module reservation_station
    import tomasulo_pkg::*;
#(
    parameter int NUM_ENTRIES = 4,
    parameter int LABEL_BASE  = 1,
    parameter int OP_W        = 4
) (
    input  logic               clk,
    input  logic               nRST,
    input  logic               IssueValid,
    output logic               IssueReady,
    input  logic [OP_W-1:0]    IssueOp,
    input  logic [DATA_W-1:0]  IssueData1,
    input  logic [DATA_W-1:0]  IssueData2,
    input  logic [LABEL_W-1:0] IssueLabel1,
    input  logic [LABEL_W-1:0] IssueLabel2,
    output logic [LABEL_W-1:0] AllocLabel,
    input  logic               BCEN,
    input  logic [LABEL_W-1:0] BClabel,
    input  logic [DATA_W-1:0]  BCdata,
    output logic               DispValid,
    input  logic               DispReady,
    output logic [OP_W-1:0]    DispOp,
    output logic [DATA_W-1:0]  DispA,
    output logic [DATA_W-1:0]  DispB,
    output logic [LABEL_W-1:0] DispLabel
);

    rs_state_t          ent_state [NUM_ENTRIES];
    logic [OP_W-1:0]    ent_op    [NUM_ENTRIES];
    logic [DATA_W-1:0]  ent_v1    [NUM_ENTRIES];
    logic [DATA_W-1:0]  ent_v2    [NUM_ENTRIES];

    logic [NUM_ENTRIES-1:0] issue_sel;
    logic [NUM_ENTRIES-1:0] disp_sel;
    logic                   free_found;
    logic                   ready_found;
    logic                   issue_fire;
    logic                   disp_fire;

    // Lowest-index FREE entry receives the next issue
    always_comb begin
        issue_sel  = '0;
        free_found = 1'b0;
        AllocLabel = NO_LABEL;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (!free_found && ent_state[i] == FREE) begin
                free_found   = 1'b1;
                issue_sel[i] = 1'b1;
                AllocLabel   = LABEL_W'(LABEL_BASE + i);
            end
        end
        IssueReady = free_found;
    end

    // Lowest-index READY entry drives the dispatch port; zeros when none
    always_comb begin
        disp_sel    = '0;
        ready_found = 1'b0;
        DispOp      = '0;
        DispA       = '0;
        DispB       = '0;
        DispLabel   = NO_LABEL;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (!ready_found && ent_state[i] == READY) begin
                ready_found = 1'b1;
                disp_sel[i] = 1'b1;
                DispOp      = ent_op[i];
                DispA       = ent_v1[i];
                DispB       = ent_v2[i];
                DispLabel   = LABEL_W'(LABEL_BASE + i);
            end
        end
        DispValid = ready_found;
    end

    assign issue_fire = IssueValid && IssueReady;
    assign disp_fire  = DispValid && DispReady;

    for (genvar g = 0; g < NUM_ENTRIES; g++) begin : g_entry
        rs_entry #(
            .OP_W  (OP_W),
            .LABEL (LABEL_BASE + g)
        ) u_entry (
            .clk          (clk),
            .nRST         (nRST),
            .issue        (issue_fire && issue_sel[g]),
            .issue_op     (IssueOp),
            .issue_data1  (IssueData1),
            .issue_data2  (IssueData2),
            .issue_label1 (IssueLabel1),
            .issue_label2 (IssueLabel2),
            .bc_en        (BCEN),
            .bc_label     (BClabel),
            .bc_data      (BCdata),
            .dispatch     (disp_fire && disp_sel[g]),
            .state        (ent_state[g]),
            .op           (ent_op[g]),
            .v1           (ent_v1[g]),
            .v2           (ent_v2[g])
        );
    end

endmodule

// File: tb/tb_reservation_station.sv
// tb/tb_reservation_station.sv - directed vector bench for reservation_station
module tb_reservation_station;

    logic        clk;
    logic        nRST;
    logic        IssueValid;
    logic        IssueReady;
    logic [3:0]  IssueOp;
    logic [31:0] IssueData1;
    logic [31:0] IssueData2;
    logic [4:0]  IssueLabel1;
    logic [4:0]  IssueLabel2;
    logic [4:0]  AllocLabel;
    logic        BCEN;
    logic [4:0]  BClabel;
    logic [31:0] BCdata;
    logic        DispValid;
    logic        DispReady;
    logic [3:0]  DispOp;
    logic [31:0] DispA;
    logic [31:0] DispB;
    logic [4:0]  DispLabel;

    int checks = 0;
    int errors = 0;

    reservation_station #(
        .NUM_ENTRIES (4),
        .LABEL_BASE  (1),
        .OP_W        (4)
    ) dut (
        .clk         (clk),
        .nRST        (nRST),
        .IssueValid  (IssueValid),
        .IssueReady  (IssueReady),
        .IssueOp     (IssueOp),
        .IssueData1  (IssueData1),
        .IssueData2  (IssueData2),
        .IssueLabel1 (IssueLabel1),
        .IssueLabel2 (IssueLabel2),
        .AllocLabel  (AllocLabel),
        .BCEN        (BCEN),
        .BClabel     (BClabel),
        .BCdata      (BCdata),
        .DispValid   (DispValid),
        .DispReady   (DispReady),
        .DispOp      (DispOp),
        .DispA       (DispA),
        .DispB       (DispB),
        .DispLabel   (DispLabel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [3:0]  op;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [4:0]  l1;
        logic [4:0]  l2;
        logic        bcen;
        logic [4:0]  bcl;
        logic [31:0] bcd;
        logic        dr;
        logic        ir;
        logic [4:0]  al;
        logic        dv;
        logic [3:0]  dop;
        logic [31:0] da;
        logic [31:0] db;
        logic [4:0]  dl;
    } vec_t;

    localparam int NV = 25;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic iv, input logic [3:0] op,
                                input logic [31:0] d1, input logic [31:0] d2,
                                input logic [4:0] l1, input logic [4:0] l2,
                                input logic bcen, input logic [4:0] bcl,
                                input logic [31:0] bcd, input logic dr,
                                input logic ir, input logic [4:0] al,
                                input logic dv, input logic [3:0] dop,
                                input logic [31:0] da, input logic [31:0] db,
                                input logic [4:0] dl);
        vec_t v;
        v.iv = iv; v.op = op; v.d1 = d1; v.d2 = d2; v.l1 = l1; v.l2 = l2;
        v.bcen = bcen; v.bcl = bcl; v.bcd = bcd; v.dr = dr;
        v.ir = ir; v.al = al; v.dv = dv; v.dop = dop; v.da = da; v.db = db; v.dl = dl;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_outs(input string tag, input logic ir, input logic [4:0] al,
                            input logic dv, input logic [3:0] dop, input logic [31:0] da,
                            input logic [31:0] db, input logic [4:0] dl);
        chk({tag, ".IssueReady"}, 32'(IssueReady), 32'(ir));
        chk({tag, ".AllocLabel"}, 32'(AllocLabel), 32'(al));
        chk({tag, ".DispValid"},  32'(DispValid),  32'(dv));
        chk({tag, ".DispOp"},     32'(DispOp),     32'(dop));
        chk({tag, ".DispA"},      DispA,           da);
        chk({tag, ".DispB"},      DispB,           db);
        chk({tag, ".DispLabel"},  32'(DispLabel),  32'(dl));
    endtask

    task automatic drive(input vec_t v);
        IssueValid  = v.iv;
        IssueOp     = v.op;
        IssueData1  = v.d1;
        IssueData2  = v.d2;
        IssueLabel1 = v.l1;
        IssueLabel2 = v.l2;
        BCEN        = v.bcen;
        BClabel     = v.bcl;
        BCdata      = v.bcd;
        DispReady   = v.dr;
    endtask

    initial begin
        //               iv op  d1     d2     l1 l2 bc bcl bcd    dr | ir al dv dop da     db     dl
        // plain issue, dispatch, free
        vecs[0]  = mk(1, 3, 32'h5,  32'h7,  0, 0, 0, 0, 32'h0,  1,  1, 1, 0, 0, 32'h0,  32'h0,  0);
        vecs[1]  = mk(0, 0, 32'h0,  32'h0,  0, 0, 0, 0, 32'h0,  1,  1, 2, 1, 3, 32'h5,  32'h7,  1);
        vecs[2]  = mk(0, 0, 32'h0,  32'h0,  0, 0, 1, 1, 32'h55, 1,  1, 2, 0, 0, 32'h0,  32'h0,  0);
        // wait on label 2, resolved by snoop (label 2's own entry is FREE)
        vecs[3]  = mk(1, 5, 32'h11, 32'h22, 2, 0, 0, 0, 32'h0,  1,  1, 1, 0, 0, 32'h0,  32'h0,  0);
        vecs[4]  = mk(0, 0, 32'h0,  32'h0,  0, 0, 0, 0, 32'h0,  1,  1, 2, 0, 0, 32'h0,  32'h0,  0);
        vecs[5]  = mk(0, 0, 32'h0,  32'h0,  0, 0, 1, 2, 32'hAB, 0,  1, 2, 0, 0, 32'h0,  32'h0,  0);
        vecs[6]  = mk(0, 0, 32'h0,  32'h0,  0, 0, 0, 0, 32'h0,  1,  1, 2, 1, 5, 32'hAB, 32'h22, 1);
        // same-cycle bypass on operand 2
        vecs[7]  = mk(1, 6, 32'h33, 32'h44, 0, 3, 1, 3, 32'h9,  1,  1, 2, 0, 0, 32'h0,  32'h0,  0);
        vecs[8]  = mk(0, 0, 32'h0,  32'h0,  0, 0, 0, 0, 32'h0,  1,  1, 3, 1, 6, 32'h33, 32'h9,  2);
        // free both executing entries
        vecs[9]  = mk(0, 0, 32'h0,  32'h0,  0, 0, 1, 1, 32'h0,  0,  1, 3, 0, 0, 32'h0,  32'h0,  0);
        vecs[10] = mk(0, 0, 32'h0,  32'h0,  0, 0, 1, 2, 32'h0,  0,  1, 1, 0, 0, 32'h0,  32'h0,  0);
        // fill all four entries, extra issue dropped
        vecs[11] = mk(1, 1, 32'h1,  32'h2,  0, 0, 0, 0, 32'h0,  0,  1, 1, 0, 0, 32'h0,  32'h0,  0);
        vecs[12] = mk(1, 2, 32'h3,  32'h4,  7, 0, 0, 0, 32'h0,  0,  1, 2, 1, 1, 32'h1,  32'h2,  1);
        vecs[13] = mk(1, 3, 32'h5,  32'h6,  0, 0, 0, 0, 32'h0,  0,  1, 3, 1, 1, 32'h1,  32'h2,  1);
        vecs[14] = mk(1, 4, 32'h7,  32'h8,  9, 9, 0, 0, 32'h0,  0,  1, 4, 1, 1, 32'h1,  32'h2,  1);
        vecs[15] = mk(1, 7, 32'h9,  32'h9,  0, 0, 0, 0, 32'h0,  0,  0, 0, 1, 1, 32'h1,  32'h2,  1);
        vecs[16] = mk(0, 0, 32'h0,  32'h0,  0, 0, 0, 0, 32'h0,  1,  0, 0, 1, 1, 32'h1,  32'h2,  1);
        // free entry 0: still full in the broadcast cycle, allocatable the next
        vecs[17] = mk(0, 0, 32'h0,  32'h0,  0, 0, 1, 1, 32'h0,  0,  0, 0, 1, 3, 32'h5,  32'h6,  3);
        vecs[18] = mk(0, 0, 32'h0,  32'h0,  0, 0, 0, 0, 32'h0,  0,  1, 1, 1, 3, 32'h5,  32'h6,  3);
        // out-of-range label 9 resolves both operands of entry 3 at once; stall 3 cycles
        vecs[19] = mk(0, 0, 32'h0,  32'h0,  0, 0, 1, 9, 32'h99, 0,  1, 1, 1, 3, 32'h5,  32'h6,  3);
        vecs[20] = mk(0, 0, 32'h0,  32'h0,  0, 0, 0, 0, 32'h0,  0,  1, 1, 1, 3, 32'h5,  32'h6,  3);
        vecs[21] = mk(0, 0, 32'h0,  32'h0,  0, 0, 0, 0, 32'h0,  0,  1, 1, 1, 3, 32'h5,  32'h6,  3);
        vecs[22] = mk(0, 0, 32'h0,  32'h0,  0, 0, 0, 0, 32'h0,  1,  1, 1, 1, 3, 32'h5,  32'h6,  3);
        vecs[23] = mk(0, 0, 32'h0,  32'h0,  0, 0, 0, 0, 32'h0,  1,  1, 1, 1, 4, 32'h99, 32'h99, 4);
        vecs[24] = mk(0, 0, 32'h0,  32'h0,  0, 0, 0, 0, 32'h0,  0,  1, 1, 0, 0, 32'h0,  32'h0,  0);

        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        nRST = 1'b1;
        #2 nRST = 1'b0;
        #2 chk_outs("reset", 1'b1, 5'd1, 1'b0, 4'd0, 32'h0, 32'h0, 5'd0);
        @(negedge clk);
        nRST = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #2 chk_outs($sformatf("vec%0d", i), vecs[i].ir, vecs[i].al, vecs[i].dv,
                        vecs[i].dop, vecs[i].da, vecs[i].db, vecs[i].dl);
        end

        // Entries 1 (waiting on label 7), 2 and 3 (executing) are busy; add a READY one
        @(negedge clk);
        drive(mk(1, 9, 32'hA, 32'hB, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        IssueValid = 1'b0;
        #2 chk_outs("pre_rst", 1'b0, 5'd0, 1'b1, 4'd9, 32'hA, 32'hB, 5'd1);
        #1 nRST = 1'b0;
        #1 chk_outs("async_rst", 1'b1, 5'd1, 1'b0, 4'd0, 32'h0, 32'h0, 5'd0);
        @(negedge clk);
        nRST = 1'b1;
        BCEN = 1'b1; BClabel = 5'd7; BCdata = 32'h77; DispReady = 1'b1;
        #2 chk_outs("post_rst_bc7", 1'b1, 5'd1, 1'b0, 4'd0, 32'h0, 32'h0, 5'd0);
        @(negedge clk);
        BClabel = 5'd3;
        #2 chk_outs("post_rst_bc3", 1'b1, 5'd1, 1'b0, 4'd0, 32'h0, 32'h0, 5'd0);
        @(negedge clk);
        BCEN = 1'b0;
        #2 chk_outs("post_rst_idle", 1'b1, 5'd1, 1'b0, 4'd0, 32'h0, 32'h0, 5'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
